// File: rtl/fht_reorder_ctrl_if.sv
// fht_reorder_ctrl_if
//   Bundles the start/status handshake, the source-RAM read port and the
//   destination-RAM write port of the FHT -> IFHT reorder sequencer.
//   Signal names keep the original i*/o* port names of the controller.
//   master : controller view (drives o*, samples i*)
//   slave  : RAM / pipeline view (drives i*, samples o*)
//   iSTART, iBYPASS_REV   start request and linear-order select
//   oRE, oADDR_RD         source read strobe and line address (all banks)
//   iDATA_0..iDATA_3      source bank read data
//   oDATA, oADDR_WR, oWE  destination write data, line address, bank enables
//   oSTART_IFHT           one-cycle start pulse to the IFHT
//   oBUSY, oRDY           transfer in progress / transfer complete
interface fht_reorder_ctrl_if #(
   parameter int D_BIT = 16,
   parameter int A_BIT = 8
);
   logic             iSTART;
   logic             iBYPASS_REV;
   logic             oRE;
   logic [A_BIT-1:0] oADDR_RD;
   logic [D_BIT-1:0] iDATA_0;
   logic [D_BIT-1:0] iDATA_1;
   logic [D_BIT-1:0] iDATA_2;
   logic [D_BIT-1:0] iDATA_3;
   logic [D_BIT-1:0] oDATA;
   logic [A_BIT-1:0] oADDR_WR;
   logic [3:0]       oWE;
   logic             oSTART_IFHT;
   logic             oBUSY;
   logic             oRDY;

   modport master (
      input  iSTART, iBYPASS_REV, iDATA_0, iDATA_1, iDATA_2, iDATA_3,
      output oRE, oADDR_RD, oDATA, oADDR_WR, oWE, oSTART_IFHT, oBUSY, oRDY
   );

   modport slave (
      output iSTART, iBYPASS_REV, iDATA_0, iDATA_1, iDATA_2, iDATA_3,
      input  oRE, oADDR_RD, oDATA, oADDR_WR, oWE, oSTART_IFHT, oBUSY, oRDY
   );
endinterface

// File: rtl/fht_reorder_ctrl.sv
// fht_reorder_ctrl
//   Moves a finished FHT result out of a 4-bank transform RAM into the input
//   RAM of the IFHT instance. Source lines are read in bit-reversed order
//   (or linear order when bypass is latched), one line every 4 cycles; each
//   line is captured into a 4-word buffer and written back one bank per
//   clock at the natural line address. After the last write the IFHT start
//   is pulsed for one cycle and oRDY is raised.
// Ports:
//   iCLK    clock
//   iRESET  synchronous reset, active-high
//   bus     fht_reorder_ctrl_if.master (start/status, read port, write port)
module fht_reorder_ctrl #(
   parameter int D_BIT  = 16,
   parameter int A_BIT  = 8,
   parameter int RD_LAT = 2
) (
   input logic                 iCLK,
   input logic                 iRESET,
   fht_reorder_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t            state;
   logic              bypass;
   logic [1:0]        rd_phase;
   logic [A_BIT-1:0]  rd_line;
   logic              rd_pending;
   logic [RD_LAT-1:0] re_pipe;
   logic [D_BIT-1:0]  line_buf [4];
   logic [A_BIT-1:0]  wr_line;
   logic [1:0]        wr_bank;
   logic              re_q;
   logic [A_BIT-1:0]  addr_rd_q;
   logic [A_BIT-1:0]  addr_wr_q;
   logic [3:0]        we_q;
   logic              start_q;
   logic              busy_q;
   logic              rdy_q;
   logic [D_BIT-1:0]  data_mux;
   logic              capture;

   function automatic logic [A_BIT-1:0] rd_map(input logic [A_BIT-1:0] line,
                                               input logic lin);
      logic [A_BIT-1:0] r;
      for (int unsigned i = 0; i < A_BIT; i++) begin
         r[i] = line[A_BIT-1-i];
      end
      return lin ? line : r;
   endfunction

   // Read data for the line issued RD_LAT cycles ago is on the bus now.
   assign capture = re_pipe[RD_LAT-1];

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state      <= ST_IDLE;
         bypass     <= 1'b0;
         rd_phase   <= '0;
         rd_line    <= '0;
         rd_pending <= 1'b0;
         re_pipe    <= '0;
         for (int unsigned b = 0; b < 4; b++) begin
            line_buf[b] <= '0;
         end
         wr_line    <= '0;
         wr_bank    <= '0;
         re_q       <= 1'b0;
         addr_rd_q  <= '0;
         addr_wr_q  <= '0;
         we_q       <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         re_pipe <= (re_pipe << 1) | RD_LAT'(re_q);
         start_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.iSTART) begin
                  state      <= ST_RUN;
                  bypass     <= bus.iBYPASS_REV;
                  // line 0 maps to address 0 in either order
                  re_q       <= 1'b1;
                  addr_rd_q  <= '0;
                  rd_line    <= A_BIT'(1);
                  rd_pending <= 1'b1;
                  rd_phase   <= '0;
                  wr_line    <= '0;
                  wr_bank    <= '0;
                  we_q       <= '0;
                  rdy_q      <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end

            ST_RUN: begin
               rd_phase <= rd_phase + 2'd1;
               re_q     <= 1'b0;
               if (rd_phase == 2'd3 && rd_pending) begin
                  re_q      <= 1'b1;
                  addr_rd_q <= rd_map(rd_line, bypass);
                  rd_line   <= rd_line + 1'b1;
                  if (rd_line == '1) begin
                     rd_pending <= 1'b0;
                  end
               end

               // In steady state the capture of line k coincides with the
               // bank-3 write of line k-1; that write reads line_buf before
               // this edge reloads it, so capture takes priority here.
               if (capture) begin
                  line_buf[0] <= bus.iDATA_0;
                  line_buf[1] <= bus.iDATA_1;
                  line_buf[2] <= bus.iDATA_2;
                  line_buf[3] <= bus.iDATA_3;
                  we_q        <= 4'b0001;
                  wr_bank     <= '0;
                  addr_wr_q   <= wr_line;
                  wr_line     <= wr_line + 1'b1;
               end else if (we_q[3]) begin
                  we_q <= '0;
                  if (addr_wr_q == '1) begin
                     state   <= ST_DONE;
                     start_q <= 1'b1;
                     rdy_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else if (we_q != '0) begin
                  we_q    <= we_q << 1;
                  wr_bank <= wr_bank + 2'd1;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      data_mux = '0;
      if (we_q != '0) begin
         data_mux = line_buf[wr_bank];
      end
   end

   assign bus.oRE         = re_q;
   assign bus.oADDR_RD    = addr_rd_q;
   assign bus.oDATA       = data_mux;
   assign bus.oADDR_WR    = addr_wr_q;
   assign bus.oWE         = we_q;
   assign bus.oSTART_IFHT = start_q;
   assign bus.oBUSY       = busy_q;
   assign bus.oRDY        = rdy_q;

endmodule

// File: tb/tb_fht_reorder_ctrl.sv
// Bench for fht_reorder_ctrl: three instances (RD_LAT = 2, 1, 4; A_BIT = 3)
// with a source RAM model whose bank b line a holds 16*b+a, a per-cycle
// output recorder and a destination RAM model.
module tb_fht_reorder_ctrl;

   localparam int DB = 16;
   localparam int AB = 3;
   localparam int N  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic [2:0] byp_v;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fht_reorder_ctrl_if #(.D_BIT(DB), .A_BIT(AB)) b0 ();
   fht_reorder_ctrl_if #(.D_BIT(DB), .A_BIT(AB)) b1 ();
   fht_reorder_ctrl_if #(.D_BIT(DB), .A_BIT(AB)) b2 ();

   fht_reorder_ctrl #(.D_BIT(DB), .A_BIT(AB), .RD_LAT(2)) u0 (.iCLK(clk), .iRESET(rst), .bus(b0));
   fht_reorder_ctrl #(.D_BIT(DB), .A_BIT(AB), .RD_LAT(1)) u1 (.iCLK(clk), .iRESET(rst), .bus(b1));
   fht_reorder_ctrl #(.D_BIT(DB), .A_BIT(AB), .RD_LAT(4)) u2 (.iCLK(clk), .iRESET(rst), .bus(b2));

   assign b0.iSTART = start_v[0];
   assign b1.iSTART = start_v[1];
   assign b2.iSTART = start_v[2];
   assign b0.iBYPASS_REV = byp_v[0];
   assign b1.iBYPASS_REV = byp_v[1];
   assign b2.iBYPASS_REV = byp_v[2];

   logic [2:0]  re_w, st_w, busy_w, rdy_w;
   logic [8:0]  ard_w, awr_w;
   logic [11:0] we_w;
   logic [47:0] dat_w;

   assign re_w   = {b2.oRE, b1.oRE, b0.oRE};
   assign st_w   = {b2.oSTART_IFHT, b1.oSTART_IFHT, b0.oSTART_IFHT};
   assign busy_w = {b2.oBUSY, b1.oBUSY, b0.oBUSY};
   assign rdy_w  = {b2.oRDY, b1.oRDY, b0.oRDY};
   assign ard_w  = {b2.oADDR_RD, b1.oADDR_RD, b0.oADDR_RD};
   assign awr_w  = {b2.oADDR_WR, b1.oADDR_WR, b0.oADDR_WR};
   assign we_w   = {b2.oWE, b1.oWE, b0.oWE};
   assign dat_w  = {b2.oDATA, b1.oDATA, b0.oDATA};

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
   endfunction

   function automatic logic [2:0] rev3(input int k);
      logic [2:0] a;
      a = k[2:0];
      return {a[0], a[1], a[2]};
   endfunction

   // Source RAM model: data for a read issued in cycle c is valid in cycle c+L.
   logic [3:0]  pv [3];
   logic [2:0]  pa [3][4];
   logic [15:0] src_d [3][4];

   always @(posedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (rst) pv[g] <= '0;
         else     pv[g] <= {pv[g][2:0], re_w[g]};
         pa[g][0] <= ard_w[3*g +: 3];
         for (int s = 1; s < 4; s++) pa[g][s] <= pa[g][s-1];
      end
   end

   always_comb begin
      for (int g = 0; g < 3; g++) begin
         for (int b = 0; b < 4; b++) begin
            if (pv[g][lat_of(g)-1] === 1'b1)
               src_d[g][b] = 16'(16*b) + 16'(pa[g][lat_of(g)-1]);
            else
               src_d[g][b] = 16'hBAD0 | 16'(b);
         end
      end
   end

   assign b0.iDATA_0 = src_d[0][0];
   assign b0.iDATA_1 = src_d[0][1];
   assign b0.iDATA_2 = src_d[0][2];
   assign b0.iDATA_3 = src_d[0][3];
   assign b1.iDATA_0 = src_d[1][0];
   assign b1.iDATA_1 = src_d[1][1];
   assign b1.iDATA_2 = src_d[1][2];
   assign b1.iDATA_3 = src_d[1][3];
   assign b2.iDATA_0 = src_d[2][0];
   assign b2.iDATA_1 = src_d[2][1];
   assign b2.iDATA_2 = src_d[2][2];
   assign b2.iDATA_3 = src_d[2][3];

   // Per-cycle output snapshots (ring indexed by absolute cycle) and destination RAM.
   logic        s_re   [3][256];
   logic [2:0]  s_ard  [3][256];
   logic [3:0]  s_we   [3][256];
   logic [2:0]  s_awr  [3][256];
   logic [15:0] s_dat  [3][256];
   logic        s_st   [3][256];
   logic        s_busy [3][256];
   logic        s_rdy  [3][256];
   logic [15:0] dest   [3][4][8];
   int          dest_t [3][4][8];

   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         s_re[g][cyc & 255]   = re_w[g];
         s_ard[g][cyc & 255]  = ard_w[3*g +: 3];
         s_we[g][cyc & 255]   = we_w[4*g +: 4];
         s_awr[g][cyc & 255]  = awr_w[3*g +: 3];
         s_dat[g][cyc & 255]  = dat_w[16*g +: 16];
         s_st[g][cyc & 255]   = st_w[g];
         s_busy[g][cyc & 255] = busy_w[g];
         s_rdy[g][cyc & 255]  = rdy_w[g];
         for (int b = 0; b < 4; b++) begin
            if (we_w[4*g+b] === 1'b1) begin
               dest[g][b][awr_w[3*g +: 3]]   = dat_w[16*g +: 16];
               dest_t[g][b][awr_w[3*g +: 3]] = cyc;
            end
         end
      end
   end

   // Pulses iSTART for one cycle; t0 is the absolute index of cycle 0.
   task automatic kick(input int g, input logic byp, output int t0);
      @(negedge clk);
      start_v[g] = 1'b1;
      byp_v[g]   = byp;
      t0 = cyc + 1;
      @(negedge clk);
      start_v[g] = 1'b0;
      byp_v[g]   = 1'b0;
   endtask

   task automatic test_reset();
      logic [29:0] v;
      rst = 1'b1;
      start_v = '0;
      byp_v = '0;
      repeat (4) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         v = {re_w[g], ard_w[3*g +: 3], we_w[4*g +: 4], awr_w[3*g +: 3],
              dat_w[16*g +: 16], st_w[g], busy_w[g], rdy_w[g]};
         checks++;
         if (v !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d: got %h, expected 0", g, v);
         end
      end
      rst = 1'b0;
   endtask

   // Full transfer in reversed order on instance g, checked every cycle.
   task automatic test_transfer(input int g);
      int L, t0, i, w, kk;
      logic [3:0] ew;
      logic [15:0] ed;
      logic eb;
      L = lat_of(g);
      kick(g, 1'b0, t0);
      repeat (4*N + L + 10) @(negedge clk);
      i = (t0 - 1) & 255;
      checks++;
      if (s_busy[g][i] !== 1'b0) begin
         errors++;
         $display("FAIL xfer_busy_pre inst=%0d: got %b, expected 0", g, s_busy[g][i]);
      end
      for (int rel = 0; rel <= 4*N + L + 4; rel++) begin
         i = (t0 + rel) & 255;
         checks++;
         if (s_re[g][i] !== ((rel % 4 == 0) && (rel < 4*N))) begin
            errors++;
            $display("FAIL xfer_re inst=%0d rel=%0d: got %b", g, rel, s_re[g][i]);
         end
         kk = (rel / 4 > N - 1) ? N - 1 : rel / 4;
         checks++;
         if (s_ard[g][i] !== rev3(kk)) begin
            errors++;
            $display("FAIL xfer_addr_rd inst=%0d rel=%0d: got %0d, expected %0d", g, rel, s_ard[g][i], rev3(kk));
         end
         w = rel - (L + 1);
         if (w >= 0 && w < 4*N) begin
            ew = 4'(1 << (w % 4));
            ed = 16'(16 * (w % 4)) + 16'(rev3(w / 4));
            checks++;
            if (s_awr[g][i] !== 3'(w / 4)) begin
               errors++;
               $display("FAIL xfer_addr_wr inst=%0d rel=%0d: got %0d, expected %0d", g, rel, s_awr[g][i], w / 4);
            end
         end else begin
            ew = 4'd0;
            ed = 16'd0;
         end
         checks++;
         if (s_we[g][i] !== ew) begin
            errors++;
            $display("FAIL xfer_we inst=%0d rel=%0d: got %b, expected %b", g, rel, s_we[g][i], ew);
         end
         checks++;
         if (s_dat[g][i] !== ed) begin
            errors++;
            $display("FAIL xfer_data inst=%0d rel=%0d: got %h, expected %h", g, rel, s_dat[g][i], ed);
         end
         checks++;
         if (s_st[g][i] !== (rel == 4*N + L + 1)) begin
            errors++;
            $display("FAIL xfer_start_ifht inst=%0d rel=%0d: got %b", g, rel, s_st[g][i]);
         end
         eb = (rel <= 4*N + L);
         checks++;
         if (s_busy[g][i] !== eb || s_rdy[g][i] !== !eb) begin
            errors++;
            $display("FAIL xfer_busy_rdy inst=%0d rel=%0d: got %b%b, expected %b%b",
                     g, rel, s_busy[g][i], s_rdy[g][i], eb, !eb);
         end
      end
      for (int k = 0; k < N; k++) begin
         for (int b = 0; b < 4; b++) begin
            ed = 16'(16 * b) + 16'(rev3(k));
            checks++;
            if (dest[g][b][k] !== ed || dest_t[g][b][k] < t0) begin
               errors++;
               $display("FAIL xfer_dest inst=%0d line=%0d bank=%0d: got %h, expected %h", g, k, b, dest[g][b][k], ed);
            end
         end
      end
   endtask

   task automatic test_bypass();
      int t0, i, kk, nst;
      logic [15:0] ed;
      kick(0, 1'b1, t0);
      repeat (4*N + 12) @(negedge clk);
      nst = 0;
      for (int rel = 0; rel <= 4*N + 6; rel++) begin
         i = (t0 + rel) & 255;
         kk = (rel / 4 > N - 1) ? N - 1 : rel / 4;
         checks++;
         if (s_ard[0][i] !== 3'(kk)) begin
            errors++;
            $display("FAIL byp_addr_rd rel=%0d: got %0d, expected %0d", rel, s_ard[0][i], kk);
         end
         if (s_st[0][i] === 1'b1) nst++;
      end
      checks++;
      if (s_we[0][(t0 + 3) & 255] !== 4'b0001 || s_we[0][(t0 + 34) & 255] !== 4'b1000) begin
         errors++;
         $display("FAIL byp_we_timing: got %b/%b, expected 0001/1000",
                  s_we[0][(t0 + 3) & 255], s_we[0][(t0 + 34) & 255]);
      end
      checks++;
      if (nst != 1 || s_st[0][(t0 + 35) & 255] !== 1'b1) begin
         errors++;
         $display("FAIL byp_start_ifht: got %0d pulses, expected 1 at rel 35", nst);
      end
      for (int k = 0; k < N; k++) begin
         for (int b = 0; b < 4; b++) begin
            ed = 16'(16 * b + k);
            checks++;
            if (dest[0][b][k] !== ed || dest_t[0][b][k] < t0) begin
               errors++;
               $display("FAIL byp_dest line=%0d bank=%0d: got %h, expected %h", k, b, dest[0][b][k], ed);
            end
         end
      end
   endtask

   task automatic test_restart_ignored();
      int t0, i, nst;
      kick(0, 1'b0, t0);
      repeat (5) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (29) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (16) @(negedge clk);
      nst = 0;
      for (int rel = 0; rel <= 50; rel++) begin
         i = (t0 + rel) & 255;
         if (s_st[0][i] === 1'b1) nst++;
         checks++;
         if (s_re[0][i] !== ((rel % 4 == 0) && (rel < 4*N))) begin
            errors++;
            $display("FAIL rst_ign_re rel=%0d: got %b", rel, s_re[0][i]);
         end
         if (rel < 4*N && rel % 4 == 0) begin
            checks++;
            if (s_ard[0][i] !== rev3(rel / 4)) begin
               errors++;
               $display("FAIL rst_ign_addr_rd rel=%0d: got %0d, expected %0d", rel, s_ard[0][i], rev3(rel / 4));
            end
         end
         if (rel >= 36) begin
            checks++;
            if (s_busy[0][i] !== 1'b0 || s_rdy[0][i] !== 1'b1) begin
               errors++;
               $display("FAIL rst_ign_idle rel=%0d: got busy=%b rdy=%b, expected busy=0 rdy=1",
                        rel, s_busy[0][i], s_rdy[0][i]);
            end
         end
      end
      checks++;
      if (nst != 1 || s_st[0][(t0 + 35) & 255] !== 1'b1) begin
         errors++;
         $display("FAIL rst_ign_start_ifht: got %0d pulses, expected 1 at rel 35", nst);
      end
   endtask

   task automatic test_abort();
      int t0, i;
      logic [29:0] v;
      kick(0, 1'b0, t0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (41) @(negedge clk);
      for (int rel = 0; rel <= 50; rel++) begin
         i = (t0 + rel) & 255;
         if (rel >= 11) begin
            v = {s_re[0][i], s_ard[0][i], s_we[0][i], s_awr[0][i], s_dat[0][i],
                 s_st[0][i], s_busy[0][i], s_rdy[0][i]};
            checks++;
            if (v !== 30'd0) begin
               errors++;
               $display("FAIL abort_outputs rel=%0d: got %h, expected 0", rel, v);
            end
         end else begin
            checks++;
            if (s_st[0][i] !== 1'b0) begin
               errors++;
               $display("FAIL abort_start_ifht rel=%0d: got %b, expected 0", rel, s_st[0][i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_transfer(0);
      test_bypass();
      test_restart_ignored();
      test_abort();
      test_transfer(0);
      test_transfer(1);
      test_transfer(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
